hwpe_stream_realign_ctrl: RTL

Address and control sequencer for a realigning stream source. It accepts a byte-granular 2-D transfer descriptor (base address, line length, line count, line stride) and emits word-aligned memory request addresses under a valid/ready handshake. With every issued word it drives the matching `ctrl_realign_t` flags and byte strobe, so that the downstream realign stage can rotate misaligned TCDM words into a dense output stream. It sits between the streamer's configuration registers and the TCDM load port / realigner pair.

---
 rtl/hwpe_stream_realign_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hwpe_stream_realign_ctrl.sv
// Address/control sequencer for a realigning stream source: walks a byte-granular
// 2-D descriptor as word-aligned requests, tagging each word with realign flags and a strobe.

package hwpe_stream_realign_pkg;

    typedef struct packed {
        logic        enable;
        logic        realign;
        logic        first;
        logic        last;
        logic        last_packet;
        logic [15:0] line_length;
    } ctrl_realign_t;

endpackage

module hwpe_stream_realign_ctrl
    import hwpe_stream_realign_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [31:0]             base_addr_i,
    input  logic [15:0]             line_bytes_i,
    input  logic [15:0]             n_lines_i,
    input  logic [31:0]             line_stride_i,
    output logic [31:0]             addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output ctrl_realign_t           ctrl_o,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned B     = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(B);
    localparam logic [B-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t           state;
    logic [OFF_W-1:0] off;
    logic             realign;
    logic [15:0]      out_words;
    logic [16:0]      fetch_words;
    logic [31:0]      line_base;
    logic [31:0]      stride;
    logic [15:0]      n_lines;
    logic [16:0]      word_cnt;
    logic [15:0]      line_cnt;

    logic             handshake;
    logic             last_word;
    logic             last_line;
    logic             start_realign;

    assign handshake     = (state == ISSUE) && addr_ready_i;
    assign last_word     = (word_cnt == fetch_words - 17'd1);
    assign last_line     = (line_cnt == n_lines - 16'd1);
    assign start_realign = (base_addr_i[OFF_W-1:0] != '0);

    // Clear shares the reset behaviour so an aborted transfer leaves no stale descriptor behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            off         <= '0;
            realign     <= 1'b0;
            out_words   <= '0;
            fetch_words <= '0;
            line_base   <= '0;
            stride      <= '0;
            n_lines     <= '0;
            word_cnt    <= '0;
            line_cnt    <= '0;
        end else if (clear_i) begin
            state       <= IDLE;
            off         <= '0;
            realign     <= 1'b0;
            out_words   <= '0;
            fetch_words <= '0;
            line_base   <= '0;
            stride      <= '0;
            n_lines     <= '0;
            word_cnt    <= '0;
            line_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        off         <= base_addr_i[OFF_W-1:0];
                        realign     <= start_realign;
                        out_words   <= line_bytes_i >> OFF_W;
                        fetch_words <= {1'b0, line_bytes_i >> OFF_W} + {16'd0, start_realign};
                        line_base   <= {base_addr_i[31:OFF_W], {OFF_W{1'b0}}};
                        stride      <= line_stride_i;
                        n_lines     <= n_lines_i;
                        word_cnt    <= '0;
                        line_cnt    <= '0;
                        if ((n_lines_i == 16'd0) || (line_bytes_i == 16'd0)) begin
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        if (last_word) begin
                            word_cnt  <= '0;
                            line_base <= line_base + stride;
                            line_cnt  <= line_cnt + 16'd1;
                            if (last_line) begin
                                state <= DONE;
                            end
                        end else begin
                            word_cnt <= word_cnt + 17'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign addr_valid_o = (state == ISSUE);
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
    assign addr_o       = line_base + (32'(word_cnt) << OFF_W);

    // A line's first word takes precedence, which covers the single aligned-word line.
    always_comb begin
        strb_o = '0;
        if (addr_valid_o) begin
            if (word_cnt == 17'd0) begin
                strb_o = ONES << off;
            end else if (last_word && realign) begin
                strb_o = ~(ONES << off);
            end else begin
                strb_o = ONES;
            end
        end
    end

    always_comb begin
        ctrl_o             = '0;
        ctrl_o.enable      = busy_o;
        ctrl_o.realign     = realign;
        ctrl_o.line_length = out_words;
        ctrl_o.first       = (word_cnt == 17'd0) && addr_valid_o;
        ctrl_o.last        = last_word && addr_valid_o;
        ctrl_o.last_packet = last_word && addr_valid_o && last_line;
    end

endmodule
